muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide coprocessor on the muldiv_* port of cpu_top.
- Accepts one operation at a time, tagged with issuing hart and destination register.
- Returns result plus the same tags as a single-cycle done pulse; cpu_top writes it back to that hart's regfile.
- Fixed latency for every op (no early-out), so hart scheduling stays deterministic.

Parameters:
XLEN, 32, operand/result width
HART_ID_W, 1, hart tag width
REG_ADDR_W, 5, destination register tag width

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
muldiv_start  input  1  request; accepted only when busy is low
muldiv_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
muldiv_a  input  XLEN  rs1 operand
muldiv_b  input  XLEN  rs2 operand
muldiv_hart_id  input  HART_ID_W  issuing hart tag
muldiv_rd  input  REG_ADDR_W  destination register tag
muldiv_busy  output  1  unit occupied
muldiv_done  output  1  one-cycle result-valid pulse
muldiv_result  output  XLEN  result, valid while done=1
muldiv_done_hart_id  output  HART_ID_W  latched hart tag, valid while done=1
muldiv_done_rd  output  REG_ADDR_W  latched rd tag, valid while done=1

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; busy=0, done=0, result=0, tags=0.
  - Any in-flight op is discarded and produces no done pulse.
- State machine: IDLE -> RUN (32 iterations) -> DONE (1 cycle) -> IDLE. busy = (state != IDLE).
- Accept: start=1 in IDLE at an edge.
  - Latch op, a, b, hart_id and rd.
  - Iteration counter loads 0.
  - Enter RUN.
- Busy and ignore rules:
  - start while busy (RUN or DONE) is ignored.
  - Input changes after accept have no effect.
- Latency: start sampled in cycle 0 -> busy=1 in cycles 1..33 -> done=1 in cycle 33 only -> busy=0 in cycle 34. Earliest next accept is in cycle 34.
- Multiply:
  - Operands are converted to magnitudes first: MULH signs both, MULHSU signs a only, MULHU and MUL unsigned.
  - 32-step shift-add into a 64-bit accumulator, one step per RUN cycle.
  - Final negate if the product sign is negative.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring shift-subtract, one quotient bit per RUN cycle on magnitudes.
  - DIV/REM use signed magnitudes: quotient negative iff signs differ; remainder takes the sign of the dividend.
- Special cases, resolved at result time with latency unchanged:
  - b=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
  - Signed overflow a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- Outputs outside DONE:
  - done=0; result and done tags hold their last values.
  - A consumer only samples them when done=1.
- rd=0 still completes and pulses done; x0 filtering belongs to writeback, not this unit.
- Reset asserted in the same cycle as start: reset wins, nothing is accepted.
- start in the DONE cycle: ignored; the pulse completes normally.

Test Plan:
- MUL a=7, b=6 at cycle 0 -> busy high cycles 1..33; done exactly in cycle 33 with result=42 and the issued hart_id/rd echoed; busy low in cycle 34.
- High-half multiplies:
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide -7 / 2:
  - DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Edge cases, each done still in cycle 33:
  - DIVU 13/0 -> 0xFFFFFFFF; REMU 13/0 -> 13.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-to-back and busy handling:
  - Second start (hart 1, rd=5) held high in cycles 1..33 -> ignored; exactly one done in cycle 33 carrying the hart 0 tag.
  - Second start in cycle 34 -> accepted; done in cycle 67 with tag hart 1, rd 5.
- Reset mid-op:
  - rst=1 in cycle 10 of a DIV -> busy=0 and done=0 from cycle 11; no done pulse ever appears for the dropped op.
  - New MUL 3x5 started after reset -> done 33 cycles later with result 15.

Source files
------------

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit, fixed latency, tagged result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int HART_ID_W  = 1,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  muldiv_start,
   input  logic [2:0]            muldiv_op,
   input  logic [XLEN-1:0]       muldiv_a,
   input  logic [XLEN-1:0]       muldiv_b,
   input  logic [HART_ID_W-1:0]  muldiv_hart_id,
   input  logic [REG_ADDR_W-1:0] muldiv_rd,
   output logic                  muldiv_busy,
   output logic                  muldiv_done,
   output logic [XLEN-1:0]       muldiv_result,
   output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
   output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

   localparam int                 c_CNT_W = $clog2(XLEN);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(XLEN - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [2:0] c_MUL    = 3'b000;
   localparam logic [2:0] c_MULH   = 3'b001;
   localparam logic [2:0] c_MULHSU = 3'b010;
   localparam logic [2:0] c_DIV    = 3'b100;
   localparam logic [2:0] c_REM    = 3'b110;
   localparam logic [2:0] c_REMU   = 3'b111;

   logic [1:0]            r_state;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [2:0]            r_op;
   logic [XLEN-1:0]       r_a_raw;
   logic                  r_b_zero;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic [XLEN-1:0]       r_mag_b;
   logic [XLEN-1:0]       r_hi;
   logic [XLEN-1:0]       r_lo;
   logic [HART_ID_W-1:0]  r_hart;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_result;
   logic [HART_ID_W-1:0]  r_done_hart;
   logic [REG_ADDR_W-1:0] r_done_rd;

   logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_is_div;
   logic [XLEN-1:0] w_a_mag, w_b_mag;
   logic [XLEN:0]   w_sum, w_shift;
   logic [XLEN-1:0] w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_next_hi, w_next_lo;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0] w_quo, w_rem, w_final;

   // Operand conditioning at accept time: everything iterates on magnitudes.
   assign w_a_signed = (muldiv_op == c_MULH) || (muldiv_op == c_MULHSU) ||
                       (muldiv_op == c_DIV)  || (muldiv_op == c_REM);
   assign w_b_signed = (muldiv_op == c_MULH) || (muldiv_op == c_DIV) ||
                       (muldiv_op == c_REM);
   assign w_a_neg    = w_a_signed && muldiv_a[XLEN-1];
   assign w_b_neg    = w_b_signed && muldiv_b[XLEN-1];
   assign w_a_mag    = w_a_neg ? -muldiv_a : muldiv_a;
   assign w_b_mag    = w_b_neg ? -muldiv_b : muldiv_b;
   assign w_is_div   = r_op[2];

   // Multiply: {r_hi,r_lo} holds partial product above the remaining multiplier bits.
   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_b} : '0);
   // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
   assign w_shift = {r_hi, r_lo[XLEN-1]};
   assign w_ge    = (w_shift >= {1'b0, r_mag_b});
   assign w_diff  = w_shift[XLEN-1:0] - r_mag_b;

   always_comb begin
      w_next_hi = w_sum[XLEN:1];
      w_next_lo = {w_sum[0], r_lo[XLEN-1:1]};
      if (w_is_div) begin
         w_next_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
         w_next_lo = {r_lo[XLEN-2:0], w_ge};
      end
   end

   assign w_prod = r_neg_q ? -{w_next_hi, w_next_lo} : {w_next_hi, w_next_lo};
   assign w_quo  = r_neg_q ? -w_next_lo : w_next_lo;
   assign w_rem  = r_neg_r ? -w_next_hi : w_next_hi;

   // Signed overflow needs no override: |a|/1 with matching signs already yields 0x80000000 rem 0.
   always_comb begin
      w_final = w_prod[2*XLEN-1:XLEN];
      if (r_op == c_MUL) begin
         w_final = w_prod[XLEN-1:0];
      end else if (w_is_div) begin
         if (r_op[1]) begin
            w_final = r_b_zero ? r_a_raw : w_rem;
         end else begin
            w_final = r_b_zero ? '1 : w_quo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_op        <= '0;
         r_a_raw     <= '0;
         r_b_zero    <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_mag_b     <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_hart      <= '0;
         r_rd        <= '0;
         r_result    <= '0;
         r_done_hart <= '0;
         r_done_rd   <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (muldiv_start) begin
                  r_state  <= c_RUN;
                  r_cnt    <= '0;
                  r_op     <= muldiv_op;
                  r_a_raw  <= muldiv_a;
                  r_b_zero <= (muldiv_b == '0);
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_hi     <= '0;
                  r_hart   <= muldiv_hart_id;
                  r_rd     <= muldiv_rd;
                  if (muldiv_op[2]) begin
                     r_mag_b <= w_b_mag;
                     r_lo    <= w_a_mag;
                  end else begin
                     r_mag_b <= w_a_mag;
                     r_lo    <= w_b_mag;
                  end
               end
            end
            c_RUN: begin
               r_hi  <= w_next_hi;
               r_lo  <= w_next_lo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  r_state     <= c_DONE;
                  r_result    <= w_final;
                  r_done_hart <= r_hart;
                  r_done_rd   <= r_rd;
               end
            end
            c_DONE:  r_state <= c_IDLE;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign muldiv_busy         = (r_state != c_IDLE);
   assign muldiv_done         = (r_state == c_DONE);
   assign muldiv_result       = r_result;
   assign muldiv_done_hart_id = r_done_hart;
   assign muldiv_done_rd      = r_done_rd;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit: results, tags, latency, busy, reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        hart;
   logic [4:0]  rd;
   logic        busy, done;
   logic [31:0] result;
   logic        done_hart;
   logic [4:0]  done_rd;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] res;
      logic        hart;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   exp_t q_exp[$];

   muldiv_unit #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .muldiv_start        (start),
      .muldiv_op           (op),
      .muldiv_a            (a),
      .muldiv_b            (b),
      .muldiv_hart_id      (hart),
      .muldiv_rd           (rd),
      .muldiv_busy         (busy),
      .muldiv_done         (done),
      .muldiv_result       (result),
      .muldiv_done_hart_id (done_hart),
      .muldiv_done_rd      (done_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sx, sy, ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      case (f)
         3'b000: begin p = ux * uy; return p[31:0]; end
         3'b001: begin p = sx * sy; return p[63:32]; end
         3'b010: begin p = sx * uy; return p[63:32]; end
         3'b011: begin p = ux * uy; return p[63:32]; end
         3'b100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sx / sy; return p[31:0];
         end
         3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Every done pulse must match the oldest outstanding expectation, in its exact cycle.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q_exp.size() == 0) begin
            check("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            exp_t e;
            e = q_exp.pop_front();
            check("result",    {32'd0, result}, {32'd0, e.res});
            check("done_hart", {63'd0, done_hart}, {63'd0, e.hart});
            check("done_rd",   {59'd0, done_rd}, {59'd0, e.rd});
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic h, input logic [4:0] r, input logic [31:0] exp);
      exp_t e;
      @(posedge clk); #1;
      start = 1'b1; op = f; a = x; b = y; hart = h; rd = r;
      e.res = exp; e.hart = h; e.rd = r; e.cyc = cyc + 33;
      q_exp.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      hart = 1'($urandom); rd = 5'($urandom);
      check("busy_c1", {63'd0, busy}, 64'd1);
      repeat (32) @(posedge clk);
      #1 check("busy_c33", {63'd0, busy}, 64'd1);
      @(posedge clk);
      #1 check("busy_c34", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hart = 1'b0; rd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",   {63'd0, busy}, 64'd0);
      check("rst_done",   {63'd0, done}, 64'd0);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_hart",   {63'd0, done_hart}, 64'd0);
      check("rst_rd",     {59'd0, done_rd}, 64'd0);
      rst = 1'b0;

      issue(3'b000, 32'd7, 32'd6, 1'b1, 5'd9, 32'd42);
      issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd1, 32'h0000_0000);
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd2, 32'hFFFF_FFFE);
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd3, 32'hFFFF_FFFF);
      issue(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd4, 32'hFFFF_FFFD);
      issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd5, 32'hFFFF_FFFF);
      issue(3'b101, 32'd100, 32'd7, 1'b1, 5'd6, 32'd14);
      issue(3'b111, 32'd100, 32'd7, 1'b0, 5'd0, 32'd2);
      issue(3'b101, 32'd13, 32'd0, 1'b1, 5'd7, 32'hFFFF_FFFF);
      issue(3'b111, 32'd13, 32'd0, 1'b0, 5'd8, 32'd13);
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd10, 32'h8000_0000);
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd11, 32'd0);
      issue(3'b100, 32'hFFFF_FFF9, 32'd0, 1'b0, 5'd12, 32'hFFFF_FFFF);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  f;
         logic [31:0] x, y;
         f = 3'(i);
         x = $urandom;
         y = (i == 5) ? 32'd0 : $urandom;
         issue(f, x, y, 1'($urandom), 5'($urandom), ref_model(f, x, y));
      end

      // Start held through the whole op is ignored until the unit is idle again.
      begin
         exp_t e;
         @(posedge clk); #1;
         c0 = cyc;
         start = 1'b1; op = 3'b000; a = 32'd11; b = 32'd13; hart = 1'b0; rd = 5'd3;
         e.res = 32'd143; e.hart = 1'b0; e.rd = 5'd3; e.cyc = c0 + 33;
         q_exp.push_back(e);
         @(posedge clk); #1;
         op = 3'b101; a = 32'd50; b = 32'd5; hart = 1'b1; rd = 5'd5;
         repeat (33) @(posedge clk);
         #1;
         check("b2b_idle_c34", {63'd0, busy}, 64'd0);
         e.res = 32'd10; e.hart = 1'b1; e.rd = 5'd5; e.cyc = c0 + 67;
         q_exp.push_back(e);
         @(posedge clk); #1;
         start = 1'b0;
         check("b2b_busy_c35", {63'd0, busy}, 64'd1);
         repeat (33) @(posedge clk);
         #1 check("b2b_idle_c68", {63'd0, busy}, 64'd0);
      end

      // Reset mid-divide drops the op with no done pulse.
      @(posedge clk); #1;
      start = 1'b1; op = 3'b100; a = 32'd1000; b = 32'd3; hart = 1'b1; rd = 5'd31;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_done", {63'd0, done}, 64'd0);
      repeat (40) @(posedge clk);
      #1 check("midrst_still_idle", {63'd0, busy}, 64'd0);

      issue(3'b000, 32'd3, 32'd5, 1'b0, 5'd15, 32'd15);

      // Reset coincident with start: nothing is accepted.
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check("sb_empty", 64'(q_exp.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
